mul_seq: RTL and testbench

MUL_SEQ -- requirements
Module: mul_seq

---
 rtl/mul_seq_if.sv | 21 ++
 rtl/mul_seq.sv | 95 +++++++++
 tb/tb_mul_seq.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mul_seq_if.sv
// Handshake bundle for mul_seq: operand request channel, result channel and status.
interface mul_seq_if;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] product;
  logic        busy;

  modport master (
    output start_valid, a, b, res_ready,
    input  start_ready, res_valid, product, busy
  );

  modport slave (
    input  start_valid, a, b, res_ready,
    output start_ready, res_valid, product, busy
  );
endinterface

// File: rtl/mul_seq.sv
// Sequential 16x16 unsigned multiplier built around a single shared 4x4 nibble multiplier;
// one nibble pair is accumulated per cycle over 16 cycles.
module mul_seq (
  input  logic      clk,
  input  logic      rst_n,
  mul_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [31:0] acc_q, acc_d;
  logic [3:0]  k_q, k_d;
  logic [31:0] product_q, product_d;

  logic [3:0]  aNib;
  logic [3:0]  bNib;
  logic [7:0]  nibProd;
  logic [2:0]  nibPos;
  logic [31:0] term;

  // k[3:2] picks the multiplicand nibble, k[1:0] the multiplier nibble; their weight is 16^(i+j).
  always_comb begin
    aNib    = a_q[{k_q[3:2], 2'b00} +: 4];
    bNib    = b_q[{k_q[1:0], 2'b00} +: 4];
    nibProd = aNib * bNib;
    nibPos  = {1'b0, k_q[3:2]} + {1'b0, k_q[1:0]};
    term    = {24'd0, nibProd} << {nibPos, 2'b00};
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    k_d       = k_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          a_d   = bus.a;
          b_d   = bus.b;
          acc_d = 32'd0;
          k_d   = 4'd0;
          if (bus.a == 16'd0 || bus.b == 16'd0) begin
            product_d = 32'd0;
            state_d   = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        acc_d = acc_q + term;
        k_d   = k_q + 4'd1;
        if (k_q == 4'd15) begin
          product_d = acc_q + term;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= 16'd0;
      b_q       <= 16'd0;
      acc_q     <= 32'd0;
      k_q       <= 4'd0;
      product_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      k_q       <= k_d;
      product_q <= product_d;
    end
  end

  assign bus.start_ready = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.res_valid   = (state_q == DONE);
  assign bus.product     = product_q;

endmodule

// File: tb/tb_mul_seq.sv
// Directed and randomized checks of mul_seq against a plain a*b reference and queue scoreboard.
module tb_mul_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mul_seq_if busIf ();

  mul_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busIf)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] expQ[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic sv, input logic [15:0] aIn, input logic [15:0] bIn, input logic rr);
    busIf.start_valid = sv;
    busIf.a           = aIn;
    busIf.b           = bIn;
    busIf.res_ready   = rr;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [31:0] refProduct(input logic [15:0] x, input logic [15:0] y);
    return {16'd0, x} * {16'd0, y};
  endfunction

  // Counts edges after the acceptance edge until res_valid is seen, giving up at the bound.
  task automatic waitResult(input int bound, output int lat);
    lat = 0;
    while (busIf.res_valid !== 1'b1 && lat < bound) begin
      step();
      lat++;
    end
  endtask

  task automatic runDirected(input string tag, input logic [15:0] aIn, input logic [15:0] bIn,
                             input int expLat, input logic [31:0] expProd);
    int lat;
    applyStimulus(1'b1, aIn, bIn, 1'b1);
    step();
    applyStimulus(1'b0, 16'hDEAD, 16'hBEEF, 1'b1);
    waitResult(40, lat);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_product"}, busIf.product, expProd);
    step();
    checkOutput({tag, "_valid_drop"}, 32'(busIf.res_valid), 32'd0);
    checkOutput({tag, "_retained"}, busIf.product, expProd);
  endtask

  initial begin
    int lat;
    int issued;
    int consumed;
    int cycles;
    logic sv;
    logic rr;
    logic [15:0] ra;
    logic [15:0] rb;

    rst_n = 1'b0;
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b0);
    repeat (3) step();
    checkOutput("rst_start_ready", 32'(busIf.start_ready), 32'd1);
    checkOutput("rst_res_valid", 32'(busIf.res_valid), 32'd0);
    checkOutput("rst_busy", 32'(busIf.busy), 32'd0);
    checkOutput("rst_product", busIf.product, 32'h0000_0000);

    rst_n = 1'b1;
    runDirected("full", 16'hFFFF, 16'hFFFF, 16, 32'hFFFE_0001);

    // Result held under backpressure while a second request waits with different operands.
    applyStimulus(1'b1, 16'h1234, 16'h5678, 1'b0);
    step();
    checkOutput("bp_busy", 32'(busIf.busy), 32'd1);
    applyStimulus(1'b1, 16'h4321, 16'h5678, 1'b0);
    waitResult(40, lat);
    checkOutput("bp_latency", 32'(lat), 32'd16);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_product", busIf.product, 32'h0626_0060);
      checkOutput("bp_valid", 32'(busIf.res_valid), 32'd1);
      checkOutput("bp_start_ready", 32'(busIf.start_ready), 32'd0);
      step();
    end
    applyStimulus(1'b1, 16'h4321, 16'h5678, 1'b1);
    step();
    checkOutput("bp_consumed", 32'(busIf.res_valid), 32'd0);
    checkOutput("bp_bubble_ready", 32'(busIf.start_ready), 32'd1);
    checkOutput("bp_bubble_product", busIf.product, 32'h0626_0060);
    step();
    checkOutput("bp_second_busy", 32'(busIf.busy), 32'd1);
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b1);
    waitResult(40, lat);
    checkOutput("bp_second_latency", 32'(lat), 32'd16);
    checkOutput("bp_second_product", busIf.product, refProduct(16'h4321, 16'h5678));
    step();

    runDirected("zero_a", 16'h0000, 16'hABCD, 0, 32'd0);
    runDirected("zero_b", 16'hABCD, 16'h0000, 0, 32'd0);

    applyStimulus(1'b1, 16'h00FF, 16'h0101, 1'b1);
    step();
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b1);
    repeat (8) step();
    rst_n = 1'b0;
    #1;
    checkOutput("abort_valid", 32'(busIf.res_valid), 32'd0);
    checkOutput("abort_busy", 32'(busIf.busy), 32'd0);
    checkOutput("abort_product", busIf.product, 32'd0);
    step();
    rst_n = 1'b1;
    runDirected("after_abort", 16'h0003, 16'h0005, 16, 32'h0000_000F);

    // Random traffic: every accepted pair is queued as a*b and must come back once, in order.
    issued   = 0;
    consumed = 0;
    cycles   = 0;
    sv       = 1'b0;
    ra       = 16'd0;
    rb       = 16'd0;
    while ((issued < 1000 || consumed < 1000) && cycles < 60000) begin
      if (!sv && issued < 1000 && $urandom_range(0, 3) != 0) begin
        sv = 1'b1;
        ra = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom());
        rb = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom());
      end
      rr = ($urandom_range(0, 2) != 0);
      applyStimulus(sv, ra, rb, rr);
      if (busIf.res_valid === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("rand_spurious", 32'(busIf.res_valid), 32'd0);
        end else if (rr) begin
          checkOutput("rand_product", busIf.product, expQ.pop_front());
          consumed++;
        end
      end
      if (sv && busIf.start_ready === 1'b1) begin
        expQ.push_back(refProduct(ra, rb));
        issued++;
        sv = 1'b0;
      end
      step();
      cycles++;
    end
    checkOutput("rand_issued", 32'(issued), 32'd1000);
    checkOutput("rand_consumed", 32'(consumed), 32'd1000);
    checkOutput("rand_leftover", 32'(expQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
